ahb_lite_sram_slave: RTL



---
 rtl/ahb_lite_sram_slave.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states, two-cycle ERROR responses
// and byte-lane writes committed at the end of the data phase.
//
// state | meaning
// IDLE  | no data phase pending, ready, OKAY
// WAIT  | OKAY data phase stalled by the wait counter
// DATA  | final OKAY data-phase cycle; write commits, read data driven
// ERR1  | first ERROR cycle (not ready)
// ERR2  | second ERROR cycle (ready)
module ahb_lite_sram_slave #(
  parameter int MEM_LOG2    = 16,
  parameter int WIN_LOG2    = 20,
  parameter int WAIT_STATES = 0,
  parameter int RO_BYTES    = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int ADDR_W = MEM_LOG2 + 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic                load;
  logic [31:0]         mem [2**MEM_LOG2];

  logic                accept, addr_err;
  logic                err_size, err_align, err_range, err_ro;
  logic [31:0]         offset;
  logic [MEM_LOG2-1:0] word_idx;
  logic [3:0]          lane_en;
  logic                unused_bits;

  // Address bits above the decoded window and HTRANS[0] carry no meaning here.
  assign unused_bits = ^{HADDR, HTRANS[0]};

  assign offset    = 32'(HADDR[WIN_LOG2-1:0]);
  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign err_size  = HSIZE > 3'd2;
  assign err_align = (HSIZE == 3'd1 && HADDR[0]) ||
                     (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
  assign err_range = offset >= (32'd1 << ADDR_W);
  assign err_ro    = HWRITE && (offset < 32'(RO_BYTES));
  assign addr_err  = err_size | err_align | err_range | err_ro;
  assign word_idx  = addr_q[ADDR_W-1:2];

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load         = 1'b0;
    case (state)
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_DATA;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end a cycle with HREADYOUT high
        state_nxt = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (addr_err) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = S_DATA;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = 4'(WAIT_STATES - 1);
          end
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    case (state)
      S_WAIT: HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      S_DATA: if (!write_q) HRDATA = mem[word_idx];
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (load) begin
        addr_q  <= HADDR[ADDR_W-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  always_comb begin
    lane_en = 4'b1111;
    case (size_q)
      2'd0:    lane_en = 4'b0001 << addr_q[1:0];
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Array is intentionally not reset so contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule
